// File: rtl/domain_pkg.sv
// Shared domain definitions for the domain-tagged register bank read path.
// A flow from src to dst is permitted when src is no more secret than dst.
package domain_pkg;

    localparam int NUM_DOM = 2;

    typedef logic dom_t;

    localparam dom_t DOM_L = 1'b0;
    localparam dom_t DOM_H = 1'b1;

    function automatic logic dom_flows(input dom_t src, input dom_t dst);
        return src <= dst;
    endfunction

endpackage

// File: rtl/dom_req_slot.sv
// Single-entry request buffer for one domain: holds the captured read
// address until the schedule serves it.
module dom_req_slot #(
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req_valid_i,
    input  logic [AW-1:0] req_addr_i,
    input  logic          serve_i,
    output logic          req_ready_o,
    output logic          full_o,
    output logic [AW-1:0] addr_o
);

    logic          full_q, full_d;
    logic [AW-1:0] addr_q, addr_d;

    // serve_i implies full, and a handshake implies empty, so they never collide.
    always_comb begin
        full_d = full_q;
        addr_d = addr_q;
        if (serve_i) begin
            full_d = 1'b0;
        end else if (req_valid_i && !full_q) begin
            full_d = 1'b1;
            addr_d = req_addr_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            full_q <= 1'b0;
            addr_q <= '0;
        end else begin
            full_q <= full_d;
            addr_q <= addr_d;
        end
    end

    assign req_ready_o = !full_q;
    assign full_o      = full_q;
    assign addr_o      = addr_q;

endmodule

// File: rtl/domain_read_port.sv
// TDM read port over a domain-tagged bank: each domain is served only at the
// start of its own fixed slot, so domain-1 activity cannot shift domain-0 timing.
module domain_read_port
    import domain_pkg::*;
#(
    parameter int  WIDTH    = 3,
    parameter int  DEPTH    = 4,
    parameter int  SLOT_LEN = 2,
    localparam int AW       = $clog2(DEPTH)
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic                            wr_en,
    input  logic [AW-1:0]                   wr_addr,
    input  logic [WIDTH-1:0]                wr_data,
    input  dom_t                            wr_dom,
    input  logic [NUM_DOM-1:0]              req_valid,
    input  logic [NUM_DOM-1:0][AW-1:0]      req_addr,
    output logic [NUM_DOM-1:0]              req_ready,
    output logic [NUM_DOM-1:0]              resp_valid,
    output logic [NUM_DOM-1:0][WIDTH-1:0]   resp_data,
    output logic [NUM_DOM-1:0]              resp_err
);

    localparam int CW = $clog2(SLOT_LEN);

    if (SLOT_LEN < 2) begin : g_bad_slot_len
        $error("domain_read_port: SLOT_LEN must be at least 2");
    end
    if ((1 << AW) != DEPTH) begin : g_bad_depth
        $error("domain_read_port: DEPTH must be a power of 2");
    end

    logic [CW-1:0]                 slot_cnt_q, slot_cnt_d;
    dom_t                          slot_owner_q, slot_owner_d;

    logic [WIDTH-1:0]              bank_data_q [DEPTH];
    dom_t                          bank_tag_q  [DEPTH];

    logic [NUM_DOM-1:0]            full;
    logic [NUM_DOM-1:0]            serve;
    logic [NUM_DOM-1:0]            rd_ok;
    logic [NUM_DOM-1:0][AW-1:0]    slot_addr;
    logic [NUM_DOM-1:0][WIDTH-1:0] rd_data;

    logic [NUM_DOM-1:0]            resp_valid_q, resp_valid_d;
    logic [NUM_DOM-1:0]            resp_err_q, resp_err_d;
    logic [NUM_DOM-1:0][WIDTH-1:0] resp_data_q, resp_data_d;

    // Free-running schedule; nothing but reset may ever influence it.
    always_comb begin
        slot_cnt_d   = slot_cnt_q + CW'(1);
        slot_owner_d = slot_owner_q;
        if (slot_cnt_q == CW'(SLOT_LEN - 1)) begin
            slot_cnt_d   = '0;
            slot_owner_d = ~slot_owner_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            slot_cnt_q   <= '0;
            slot_owner_q <= DOM_L;
        end else begin
            slot_cnt_q   <= slot_cnt_d;
            slot_owner_q <= slot_owner_d;
        end
    end

    // Reads in the write cycle see the pre-write entry.
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                bank_data_q[i] <= '0;
                bank_tag_q[i]  <= DOM_L;
            end
        end else if (wr_en) begin
            bank_data_q[wr_addr] <= wr_data;
            bank_tag_q[wr_addr]  <= wr_dom;
        end
    end

    for (genvar d = 0; d < NUM_DOM; d++) begin : g_dom
        dom_req_slot #(
            .AW (AW)
        ) u_slot (
            .clk         (clk),
            .rst         (rst),
            .req_valid_i (req_valid[d]),
            .req_addr_i  (req_addr[d]),
            .serve_i     (serve[d]),
            .req_ready_o (req_ready[d]),
            .full_o      (full[d]),
            .addr_o      (slot_addr[d])
        );

        assign serve[d]   = full[d] && (slot_owner_q == dom_t'(d)) && (slot_cnt_q == '0);
        assign rd_data[d] = bank_data_q[slot_addr[d]];
        assign rd_ok[d]   = dom_flows(bank_tag_q[slot_addr[d]], dom_t'(d));
    end

    always_comb begin
        resp_valid_d = serve;
        resp_data_d  = resp_data_q;
        resp_err_d   = resp_err_q;
        for (int d = 0; d < NUM_DOM; d++) begin
            if (serve[d]) begin
                resp_data_d[d] = rd_ok[d] ? rd_data[d] : '0;
                resp_err_d[d]  = ~rd_ok[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            resp_valid_q <= '0;
            resp_data_q  <= '0;
            resp_err_q   <= '0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_data_q  <= resp_data_d;
            resp_err_q   <= resp_err_d;
        end
    end

    assign resp_valid = resp_valid_q;
    assign resp_data  = resp_data_q;
    assign resp_err   = resp_err_q;

endmodule

// File: tb/tb_domain_read_port.sv
// Self-checking bench for domain_read_port: table-driven reads plus hand-built
// corner sequences, all checked through a per-domain expected-response queue.
module tb_domain_read_port;
    import domain_pkg::*;

    localparam int WIDTH = 3;
    localparam int DEPTH = 4;
    localparam int SL    = 2;
    localparam int AW    = 2;
    localparam int P     = 2 * SL;
    localparam int NREC  = 80;

    logic                    clk = 1'b0;
    logic                    rst;
    logic                    wr_en;
    logic [AW-1:0]           wr_addr;
    logic [WIDTH-1:0]        wr_data;
    dom_t                    wr_dom;
    logic [1:0]              req_valid;
    logic [1:0][AW-1:0]      req_addr;
    logic [1:0]              req_ready;
    logic [1:0]              resp_valid;
    logic [1:0][WIDTH-1:0]   resp_data;
    logic [1:0]              resp_err;

    always #5 clk = ~clk;

    domain_read_port #(.WIDTH(WIDTH), .DEPTH(DEPTH), .SLOT_LEN(SL)) dut (
        .clk        (clk),
        .rst        (rst),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_dom     (wr_dom),
        .req_valid  (req_valid),
        .req_addr   (req_addr),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_data  (resp_data),
        .resp_err   (resp_err)
    );

    typedef struct {
        int data;
        int err;
        int due;
    } exp_t;

    typedef struct {
        int dom;
        int addr;
        int xd;
        int xe;
    } vec_t;

    exp_t q0[$];
    exp_t q1[$];
    int   rc0[$];
    int   nresp1 = 0;
    int   nchk   = 0;
    int   npass  = 0;
    int   cyc    = 0;
    int   ph     = 0;
    bit   stop   = 1'b0;

    int   m_data [DEPTH];
    int   m_tag  [DEPTH];
    logic [WIDTH+2:0] rec [2][NREC];

    // Reference schedule phase: 0..SL-1 belongs to domain 0, SL..P-1 to domain 1.
    always @(posedge clk) begin
        cyc <= cyc + 1;
        ph  <= rst ? 0 : (ph + 1) % P;
    end

    task automatic check(input string name, input int got, input int want);
        nchk++;
        if (got == want) npass++;
        else $display("FAIL %s: got %0d, want %0d (cycle %0d)", name, got, want, cyc);
    endtask

    always @(negedge clk) begin : mon
        exp_t e;
        if (resp_valid[0]) begin
            if (q0.size() == 0) begin
                check("resp0_unexpected", 1, 0);
            end else begin
                e = q0.pop_front();
                check("resp0_data", int'(resp_data[0]), e.data);
                check("resp0_err", int'(resp_err[0]), e.err);
                check("resp0_cycle", cyc, e.due);
            end
            rc0.push_back(cyc);
        end
        if (resp_valid[1]) begin
            nresp1++;
            if (q1.size() == 0) begin
                check("resp1_unexpected", 1, 0);
            end else begin
                e = q1.pop_front();
                check("resp1_data", int'(resp_data[1]), e.data);
                check("resp1_err", int'(resp_err[1]), e.err);
                check("resp1_cycle", cyc, e.due);
            end
        end
    end

    function automatic int due_from(input int p, input int d, input int c);
        int k = 1;
        while ((p + k) % P != d * SL) k++;
        return c + k + 1;
    endfunction

    task automatic apply_reset;
        @(posedge clk); #1;
        rst       = 1'b1;
        req_valid = '0;
        wr_en     = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        q0.delete();
        q1.delete();
        rc0.delete();
        nresp1 = 0;
        for (int i = 0; i < DEPTH; i++) begin
            m_data[i] = 0;
            m_tag[i]  = 0;
        end
    endtask

    task automatic wr(input int a, input int dv, input int t);
        wr_en   = 1'b1;
        wr_addr = AW'(a);
        wr_data = WIDTH'(dv);
        wr_dom  = dom_t'(t);
        @(posedge clk); #1;
        wr_en     = 1'b0;
        m_data[a] = dv;
        m_tag[a]  = t;
    endtask

    task automatic wait_phase(input int p);
        for (int n = 0; n < 4 * P && ph != p; n++) begin
            @(posedge clk); #1;
        end
        if (ph != p) check("phase_align", ph, p);
    endtask

    task automatic do_req(input int d, input int a, input int xd, input int xe, output int hs);
        exp_t e;
        bit   got = 1'b0;
        hs           = -1;
        req_valid[d] = 1'b1;
        req_addr[d]  = AW'(a);
        for (int n = 0; n < 64; n++) begin
            @(negedge clk);
            if (req_ready[d]) begin
                got    = 1'b1;
                hs     = cyc;
                e.data = xd;
                e.err  = xe;
                e.due  = due_from(ph, d, cyc);
                if (d == 0) q0.push_back(e);
                else q1.push_back(e);
            end
            @(posedge clk); #1;
            if (got) break;
        end
        req_valid[d] = 1'b0;
        if (!got) check($sformatf("req%0d_timeout", d), 0, 1);
    endtask

    task automatic drain;
        for (int n = 0; n < 64 && (q0.size() + q1.size()) != 0; n++) begin
            @(posedge clk); #1;
        end
        check("drain_pending", q0.size() + q1.size(), 0);
    endtask

    initial begin
        #300000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vec_t tbl[8];
        int   hs;
        int   diffs;
        int   first_diff;
        int   lresp;
        int   lseq[6];

        rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_dom = DOM_L;
        req_valid = '0; req_addr = '0;

        // Reset state
        apply_reset;
        @(negedge clk);
        check("rst_req_ready", int'(req_ready), 3);
        check("rst_resp_valid", int'(resp_valid), 0);
        check("rst_resp_data", int'(resp_data), 0);
        check("rst_resp_err", int'(resp_err), 0);
        check("rst_slot_owner", int'(dut.slot_owner_q), 0);
        @(posedge clk); #1;

        // Best-case latency: handshake in the cycle just before domain 0's service point
        wr(2, 5, 0);
        wait_phase(P - 1);
        do_req(0, 2, 5, 0, hs);
        repeat (3) @(posedge clk);
        #1;
        check("best_latency_count", rc0.size(), 1);
        if (rc0.size() == 1) check("best_latency", rc0[0] - hs, 2);
        drain;

        // Worst case: handshake on the service cycle waits a full round
        rc0.delete();
        wait_phase(0);
        do_req(0, 2, 5, 0, hs);
        drain;
        check("worst_latency_count", rc0.size(), 1);
        if (rc0.size() == 1) check("worst_latency", rc0[0] - hs, P + 1);

        // Table-driven tag checks
        wr(0, 3, 0);
        wr(1, 6, 1);
        wr(2, 5, 0);
        wr(3, 4, 1);
        tbl[0] = '{0, 1, 0, 1};
        tbl[1] = '{1, 1, 6, 0};
        tbl[2] = '{0, 2, 5, 0};
        tbl[3] = '{1, 2, 5, 0};
        tbl[4] = '{0, 3, 0, 1};
        tbl[5] = '{1, 3, 4, 0};
        tbl[6] = '{0, 0, 3, 0};
        tbl[7] = '{1, 0, 3, 0};
        for (int i = 0; i < 8; i++) begin
            do_req(tbl[i].dom, tbl[i].addr, tbl[i].xd, tbl[i].xe, hs);
        end
        drain;

        // Write and service of the same entry in the same cycle
        wr(3, 2, 0);
        wait_phase(P - 1);
        req_valid[0] = 1'b1;
        req_addr[0]  = 2'd3;
        @(negedge clk);
        check("sc_req_ready", int'(req_ready[0]), 1);
        q0.push_back('{2, 0, cyc + 2});
        @(posedge clk); #1;
        req_valid[0] = 1'b0;
        check("sc_service_phase", ph, 0);
        wr(3, 7, 0);
        drain;
        do_req(0, 3, 7, 0, hs);
        drain;

        // Reset while domain 1 holds a pending request
        wait_phase(SL);
        do_req(1, 0, 3, 0, hs);
        @(posedge clk); #1;
        apply_reset;
        @(negedge clk);
        check("mid_rst_slot_owner", int'(dut.slot_owner_q), 0);
        check("mid_rst_slot_cnt", int'(dut.slot_cnt_q), 0);
        check("mid_rst_req_ready", int'(req_ready), 3);
        repeat (3 * P) @(posedge clk);
        #1;
        check("mid_rst_no_resp1", nresp1, 0);

        // Back-to-back domain-0 requests
        wr(0, 1, 0);
        wr(1, 2, 0);
        wr(2, 3, 0);
        wr(3, 6, 1);
        rc0.delete();
        for (int i = 0; i < 4; i++) begin
            do_req(0, i, (m_tag[i] != 0) ? 0 : m_data[i], m_tag[i], hs);
        end
        drain;
        check("b2b_resp_count", rc0.size(), 4);
        for (int i = 1; i < rc0.size(); i++) check($sformatf("b2b_spacing%0d", i), rc0[i] - rc0[i-1], P);

        // Noninterference: same domain-0 traffic with domain 1 idle, then saturating
        lseq = '{0, 1, 2, 3, 2, 1};
        for (int r = 0; r < 2; r++) begin
            apply_reset;
            wr(0, 3, 0);
            wr(1, 6, 1);
            wr(2, 5, 0);
            wr(3, 1, 1);
            stop = 1'b0;
            fork
                begin
                    int hl;
                    for (int i = 0; i < 6; i++) begin
                        do_req(0, lseq[i], (m_tag[lseq[i]] != 0) ? 0 : m_data[lseq[i]],
                               m_tag[lseq[i]], hl);
                        repeat (i % 3) begin
                            @(posedge clk); #1;
                        end
                    end
                end
                begin
                    for (int n = 0; n < NREC; n++) begin
                        @(negedge clk);
                        rec[r][n] = {req_ready[0], resp_valid[0], resp_data[0], resp_err[0]};
                    end
                    stop = 1'b1;
                end
                begin
                    int hh;
                    int ha;
                    ha = 0;
                    if (r == 1) begin
                        while (!stop) begin
                            do_req(1, ha, m_data[ha], 0, hh);
                            ha = (ha == 0) ? 2 : 0;
                        end
                    end
                end
                begin
                    int wa;
                    if (r == 1) begin
                        while (!stop) begin
                            wa      = ($urandom_range(0, 1) == 0) ? 1 : 3;
                            wr_en   = 1'b1;
                            wr_addr = AW'(wa);
                            wr_data = WIDTH'($urandom);
                            wr_dom  = DOM_H;
                            @(posedge clk); #1;
                            m_data[wa] = int'(wr_data);
                            m_tag[wa]  = 1;
                        end
                        wr_en = 1'b0;
                    end
                end
            join
            drain;
        end
        diffs      = 0;
        first_diff = -1;
        lresp      = 0;
        for (int n = 0; n < NREC; n++) begin
            if (rec[0][n] !== rec[1][n]) begin
                diffs++;
                if (first_diff < 0) first_diff = n;
            end
            if (rec[0][n][WIDTH+1]) lresp++;
        end
        if (diffs != 0) $display("first domain-0 divergence at recorded cycle %0d", first_diff);
        check("noninterference_diffs", diffs, 0);
        check("ni_l_resp_count", lresp, 6);

        $display("%0d/%0d checks passed", npass, nchk);
        $finish;
    end

endmodule
